// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared RV32I core definitions. Holds next-PC select codes,
//                the fetch FSM state type, base opcodes used by the address
//                builder, reset defaults and a small alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Next-PC select codes driven by the address builder.
    localparam logic [1:0] PC_SEL_HOLD = 2'b00;
    localparam logic [1:0] PC_SEL_PC4  = 2'b01;
    localparam logic [1:0] PC_SEL_ARB  = 2'b10;

    // Fetch unit state machine.
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    // RV32I base opcodes (instr[6:0]) as used by the address builder.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Reset defaults for the fetch unit.
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    // RV32I without the C extension requires word-aligned fetch targets.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC selection.
//                  pc        in  32  current PC
//                  pc_sel    in   2  00 hold, 01 PC+4, 10 pc_AB, 11 as 01
//                  pc_AB     in  32  arbitrary target
//                  next_pc   out 32  selected next PC (pc when misaligned)
//                  misaligned out 1  pc_AB chosen but not word aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc_AB,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    localparam logic [31:0] C_INSTR_BYTES = 32'd4;

    always_comb begin
        next_pc    = pc;
        misaligned = 1'b0;
        case (pc_sel)
            PC_SEL_HOLD: next_pc = pc;
            PC_SEL_PC4:  next_pc = pc + C_INSTR_BYTES;   // wraps modulo 2^32
            PC_SEL_ARB: begin
                // A misaligned target leaves the PC where it is; the caller halts.
                if (is_word_aligned(pc_AB)) begin
                    next_pc = pc_AB;
                end else begin
                    misaligned = 1'b1;
                end
            end
            default:     next_pc = pc + C_INSTR_BYTES;   // reserved code behaves as PC+4
        endcase
    end

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Non-pipelined RV32I instruction fetch. Owns the PC, fetches
//                one word over a req/ack handshake, presents it to decode and
//                waits for the address builder to retire it and pick the next
//                PC.
//  Ports       : clk, rst_n (sync, active-low)
//                pc_sel[1:0], pc_AB[31:0], ctrl_valid   - retire / next PC
//                imem_req, imem_addr[31:0], imem_ack, imem_rdata[31:0]
//                instr_valid, instr_ready, instr[31:0], pc_out[31:0]
//                fetch_fault (sticky), instret[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc_AB,
    input  logic        ctrl_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        fetch_fault,
    output logic [31:0] instret
);

    localparam logic [31:0] C_ONE = 32'd1;

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_fault;
    logic [31:0] r_instret;

    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_retire;

    next_pc_calc u_next_pc_calc (
        .pc         (r_pc),
        .pc_sel     (pc_sel),
        .pc_AB      (pc_AB),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. ctrl_valid only counts once decode has taken the
    // instruction (same cycle in S_ISSUE, or any later cycle in S_EXEC).
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_BOOT: begin
                // One idle cycle with imem_req low lets a stale ack drain.
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (ctrl_valid) begin
                        w_retire     = 1'b1;
                        w_next_state = w_misaligned ? S_HALT : S_FETCH;
                    end else begin
                        w_next_state = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (ctrl_valid) begin
                    w_retire     = 1'b1;
                    w_next_state = w_misaligned ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    // Datapath: fetched word capture, PC update, fault flag, retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_pc_out  <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_fault   <= 1'b0;
            r_instret <= '0;
        end else begin
            if ((r_state == S_FETCH) && imem_ack) begin
                r_instr  <= imem_rdata;
                r_pc_out <= r_pc;
            end
            if (w_retire) begin
                if (w_misaligned) begin
                    // Faulting jump does not retire and leaves the PC intact.
                    r_fault <= 1'b1;
                end else begin
                    r_pc      <= w_next_pc;
                    r_instret <= r_instret + C_ONE;
                end
            end
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_ISSUE);
    assign instr       = instr_valid ? r_instr : NOP_INSTR;
    assign pc_out      = r_pc_out;
    assign fetch_fault = r_fault;
    assign instret     = r_instret;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Directed vector
//                table, randomized instruction stream against a transaction
//                level PC/instret model, and reset-mid-fetch sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] pc_AB = 32'h0;
    logic        ctrl_valid = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        fetch_fault;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .pc_AB       (pc_AB),
        .ctrl_valid  (ctrl_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .fetch_fault (fetch_fault),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory image: a fixed word at 0, a recognizable address-derived word elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0013);
    endfunction

    // Advance one clock and sample just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        ctrl_valid  = 1'b0;
        cyc();
        check1 ("rst_imem_req",    imem_req,    1'b0);
        check1 ("rst_instr_valid", instr_valid, 1'b0);
        check32("rst_imem_addr",   imem_addr,   32'h0);
        check32("rst_pc_out",      pc_out,      32'h0);
        check32("rst_instr",       instr,       32'h0000_0013);
        check1 ("rst_fetch_fault", fetch_fault, 1'b0);
        check32("rst_instret",     instret,     32'h0);
        rst_n = 1'b1;
    endtask

    // Serve one fetch: wait for the request, keep it pending for wait_st cycles
    // (poking ctrl_valid, which must be ignored), then ack and check decode side.
    task automatic fetch_check(input logic [31:0] addr, input int wait_st, output int lat);
        logic [31:0] ir_before;
        lat = 0;
        ir_before = instret;
        while (imem_req !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
        check1("fetch_req_seen", imem_req, 1'b1);
        if (imem_req === 1'b1) begin
            for (int k = 0; k <= wait_st; k++) begin
                check32("fetch_addr", imem_addr, addr);
                check1 ("fetch_req_held", imem_req, 1'b1);
                check1 ("fetch_no_valid", instr_valid, 1'b0);
                if (k == wait_st) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(addr);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    ctrl_valid = 1'b1;
                    pc_sel     = 2'b01;
                end
                cyc();
                imem_ack   = 1'b0;
                ctrl_valid = 1'b0;
            end
            check1 ("issue_valid",   instr_valid, 1'b1);
            check32("issue_instr",   instr,       mem_word(addr));
            check32("issue_pc_out",  pc_out,      addr);
            check1 ("issue_req_low", imem_req,    1'b0);
            check32("fetch_instret_held", instret, ir_before);
        end
    endtask

    // Hand the instruction to decode and retire it with the given next-PC choice.
    task automatic retire(input logic [1:0] sel, input logic [31:0] ab,
                          input bit combined, input int idle, input bit stall);
        pc_sel = sel;
        pc_AB  = ab;
        if (stall) begin
            instr_ready = 1'b0;
            cyc();
            check1("stall_valid_held", instr_valid, 1'b1);
        end
        if (combined) begin
            instr_ready = 1'b1;
            ctrl_valid  = 1'b1;
            cyc();
            instr_ready = 1'b0;
            ctrl_valid  = 1'b0;
        end else begin
            instr_ready = 1'b1;
            cyc();
            instr_ready = 1'b0;
            check1("accept_valid_drop", instr_valid, 1'b0);
            for (int i = 0; i < idle; i++) begin
                check1("exec_req_low", imem_req, 1'b0);
                cyc();
            end
            ctrl_valid = 1'b1;
            cyc();
            ctrl_valid = 1'b0;
        end
    endtask

    // After a faulting retire: halted, sticky flag, nothing retires or fetches.
    task automatic check_halt(input logic [31:0] exp_instret);
        check1 ("fault_flag", fetch_fault, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ctrl_valid  = 1'b1;
            instr_ready = 1'b1;
            pc_sel      = 2'b01;
            imem_ack    = 1'b1;
            check1("halt_req_low",   imem_req,    1'b0);
            check1("halt_valid_low", instr_valid, 1'b0);
            cyc();
        end
        ctrl_valid  = 1'b0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        check32("halt_instret", instret, exp_instret);
        check1 ("halt_fault_sticky", fetch_fault, 1'b1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] ab;
        bit          combined;
        int          wait_next;
        logic [31:0] exp_next;
        bit          exp_fault;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat;
        logic [31:0] m_pc;
        logic [31:0] m_instret;
        logic [31:0] ab;
        logic [31:0] r;
        logic [1:0]  sel;
        bit          fault;

        vecs[0] = '{2'b01, 32'h0000_0000, 1'b0, 3, 32'h0000_0004, 1'b0, 32'd1};
        vecs[1] = '{2'b10, 32'h0000_0100, 1'b0, 1, 32'h0000_0100, 1'b0, 32'd2};
        vecs[2] = '{2'b00, 32'h0000_0000, 1'b0, 0, 32'h0000_0100, 1'b0, 32'd3};
        vecs[3] = '{2'b11, 32'h0000_0000, 1'b1, 2, 32'h0000_0104, 1'b0, 32'd4};
        vecs[4] = '{2'b10, 32'hFFFF_FFFC, 1'b0, 0, 32'hFFFF_FFFC, 1'b0, 32'd5};
        vecs[5] = '{2'b01, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b0, 32'd6};
        vecs[6] = '{2'b10, 32'h0000_0102, 1'b0, 0, 32'h0000_0000, 1'b1, 32'd6};

        // Directed table.
        do_reset();
        fetch_check(32'h0, 0, lat);
        check32("boot_latency", lat, 32'd1);
        for (int i = 0; i < 7; i++) begin
            retire(vecs[i].sel, vecs[i].ab, vecs[i].combined, i % 3, (i % 2) == 1);
            check32("vec_instret", instret, vecs[i].exp_instret);
            if (vecs[i].exp_fault) begin
                check_halt(vecs[i].exp_instret);
            end else begin
                check1("vec_req_next_cycle", imem_req, 1'b1);
                fetch_check(vecs[i].exp_next, vecs[i].wait_next, lat);
                check32("vec_refetch_latency", lat, 32'd0);
            end
        end

        // Recovery from the halt through reset.
        do_reset();
        fetch_check(32'h0, 0, lat);
        check32("reboot_latency", lat, 32'd1);

        // Randomized instruction stream against a PC/instret model.
        m_pc      = 32'h0;
        m_instret = 32'h0;
        for (int n = 0; n < 60; n++) begin
            sel = 2'($urandom_range(0, 3));
            r   = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                ab = {r[31:2], 2'($urandom_range(1, 3))};
            end else begin
                ab = {r[31:2], 2'b00};
            end
            if ($urandom_range(0, 3) == 0) begin
                ab = 32'hFFFF_FFFC;
            end
            fault = (sel == 2'b10) && (ab[1:0] != 2'b00);
            if (!fault) begin
                if (sel == 2'b00)      m_pc = m_pc;
                else if (sel == 2'b10) m_pc = ab;
                else                   m_pc = m_pc + 32'd4;
                m_instret = m_instret + 32'd1;
            end
            retire(sel, ab, bit'($urandom_range(0, 1)), $urandom_range(0, 2),
                   bit'($urandom_range(0, 1)));
            check32("rnd_instret", instret, m_instret);
            if (fault) begin
                check_halt(m_instret);
                do_reset();
                m_pc      = 32'h0;
                m_instret = 32'h0;
                fetch_check(m_pc, $urandom_range(0, 3), lat);
                check32("rnd_reboot_latency", lat, 32'd1);
            end else begin
                check1("rnd_req_next_cycle", imem_req, 1'b1);
                fetch_check(m_pc, $urandom_range(0, 3), lat);
                check32("rnd_fetch_latency", lat, 32'd0);
            end
        end

        // Reset while a request is outstanding; the late ack must be ignored.
        retire(2'b10, 32'h0000_0200, 1'b1, 0, 1'b0);
        check1 ("midrst_req_before", imem_req, 1'b1);
        check32("midrst_addr_before", imem_addr, 32'h0000_0200);
        rst_n = 1'b0;
        cyc();
        check1 ("midrst_req_dropped", imem_req, 1'b0);
        check32("midrst_addr_reset", imem_addr, 32'h0);
        check1 ("midrst_valid_low", instr_valid, 1'b0);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        cyc();
        imem_ack = 1'b0;
        check1 ("midrst_late_ack_ignored", instr_valid, 1'b0);
        check1 ("midrst_fetch_req", imem_req, 1'b1);
        check32("midrst_fetch_addr", imem_addr, 32'h0);
        fetch_check(32'h0, 1, lat);
        check32("midrst_fetch_latency", lat, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
